// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a start/busy/valid handshake; MUL, SLL and SRA iterate in EXEC.
// Define ALU_SEQ_OVERFLOW_EN to add the registered OVERFLOW output.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             VALID,
    output logic             BUSY
`ifdef ALU_SEQ_OVERFLOW_EN
    ,
    output logic             OVERFLOW
`endif
);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;
    localparam int CW = $clog2(WIDTH + 1);
    // The full double-width product is only kept when its upper half is needed for overflow.
`ifdef ALU_SEQ_OVERFLOW_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic [AW-1:0]    acc_reg;
    logic [AW-1:0]    mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             valid_reg;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] quick_res;
    logic             goes_exec;
    logic [AW-1:0]    acc_next;
    logic [AW-1:0]    mcand_next;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] step_res;

    assign shamt     = DATA2[SHW-1:0];
    assign sum       = DATA1 + DATA2;
    assign diff      = DATA1 - DATA2;
    assign goes_exec = (SELECT == OP_MUL) ||
                       (((SELECT == OP_SLL) || (SELECT == OP_SRA)) && (shamt != '0));

    always_comb begin
        case (SELECT)
            OP_FWD:  quick_res = DATA2;
            OP_ADD:  quick_res = sum;
            OP_AND:  quick_res = DATA1 & DATA2;
            OP_OR:   quick_res = DATA1 | DATA2;
            OP_SUB:  quick_res = diff;
            default: quick_res = DATA1;   // shift by zero passes the operand through
        endcase
    end

    // mcand_reg doubles as the shift register for SLL/SRA.
    always_comb begin
        acc_next = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;
        if (op_reg == OP_SLL) begin
            shift_next = mcand_reg[WIDTH-1:0] << 1;
        end else begin
            shift_next = {mcand_reg[WIDTH-1], mcand_reg[WIDTH-1:1]};
        end
        mcand_next = (op_reg == OP_MUL) ? (mcand_reg << 1) : AW'(shift_next);
        step_res   = (op_reg == OP_MUL) ? acc_next[WIDTH-1:0] : shift_next;
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    logic ov_sticky_reg;
    logic overflow_reg;
    logic quick_ov;
    logic step_ov;
    logic sll_sticky_next;

    // An SLL overflows iff some step shifts out a bit differing from the new sign bit.
    assign sll_sticky_next = ov_sticky_reg | (mcand_reg[WIDTH-1] ^ mcand_reg[WIDTH-2]);

    always_comb begin
        case (SELECT)
            OP_ADD:  quick_ov = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (sum[WIDTH-1] != DATA1[WIDTH-1]);
            OP_SUB:  quick_ov = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (diff[WIDTH-1] != DATA1[WIDTH-1]);
            default: quick_ov = 1'b0;
        endcase
        case (op_reg)
            OP_MUL:  step_ov = |acc_next[AW-1:WIDTH];
            OP_SLL:  step_ov = sll_sticky_next;
            default: step_ov = 1'b0;
        endcase
    end

    assign OVERFLOW = overflow_reg;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg  <= IDLE;
            op_reg     <= OP_FWD;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            valid_reg  <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
            ov_sticky_reg <= 1'b0;
            overflow_reg  <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (START) begin
                        if (goes_exec) begin
                            state_reg  <= EXEC;
                            op_reg     <= SELECT;
                            acc_reg    <= '0;
                            mcand_reg  <= AW'(DATA1);
                            mplier_reg <= DATA2;
                            count_reg  <= (SELECT == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
`ifdef ALU_SEQ_OVERFLOW_EN
                            ov_sticky_reg <= 1'b0;
`endif
                        end else begin
                            result_reg <= quick_res;
                            zero_reg   <= (quick_res == '0);
                            valid_reg  <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
                            overflow_reg <= quick_ov;
`endif
                        end
                    end
                end
                EXEC: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_next;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg - CW'(1);
`ifdef ALU_SEQ_OVERFLOW_EN
                    ov_sticky_reg <= sll_sticky_next;
`endif
                    if (count_reg == CW'(1)) begin
                        state_reg  <= IDLE;
                        result_reg <= step_res;
                        zero_reg   <= (step_res == '0);
                        valid_reg  <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
                        overflow_reg <= step_ov;
`endif
                    end
                end
            endcase
        end
    end

    assign RESULT = result_reg;
    assign ZERO   = zero_reg;
    assign VALID  = valid_reg;
    assign BUSY   = (state_reg == EXEC);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): expectations queued at START, checked when due.
// Overflow checks are compiled in only when ALU_SEQ_OVERFLOW_EN is defined.
module tb_alu_seq;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    logic       CLK    = 1'b0;
    logic       RESET  = 1'b0;
    logic       START  = 1'b0;
    logic [2:0] SELECT = 3'b000;
    logic [7:0] DATA1  = 8'h00;
    logic [7:0] DATA2  = 8'h00;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       VALID;
    logic       BUSY;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic       OVERFLOW;
`endif

    alu_seq #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .ZERO   (ZERO),
        .VALID  (VALID),
        .BUSY   (BUSY)
`ifdef ALU_SEQ_OVERFLOW_EN
        ,
        .OVERFLOW (OVERFLOW)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        int         due;
        logic       ov;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0]       p;
        logic signed [7:0] s;
        p = {8'h00, a} * {8'h00, b};
        s = a;
        case (op)
            OP_FWD:  return b;
            OP_ADD:  return a + b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SUB:  return a - b;
            OP_MUL:  return p[7:0];
            OP_SLL:  return a << b[2:0];
            default: return s >>> b[2:0];
        endcase
    endfunction

    function automatic logic model_ov(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [7:0]  r;
        p = {8'h00, a} * {8'h00, b};
        r = a + b;
        if (op == OP_ADD) return (a[7] == b[7]) && (r[7] != a[7]);
        r = a - b;
        if (op == OP_SUB) return (a[7] != b[7]) && (r[7] != a[7]);
        if (op == OP_MUL) return p[15:8] != 8'h00;
        r = a << b[2:0];
        if (op == OP_SLL) return ($signed(r) >>> b[2:0]) != $signed(a);
        return 1'b0;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [7:0] b);
        if (op == OP_MUL) return 9;
        if ((op == OP_SLL || op == OP_SRA) && b[2:0] != 3'd0) return int'(b[2:0]) + 1;
        return 1;
    endfunction

    // Monitor: each due expectation must meet a VALID pulse; VALID is low at all other times.
    always @(negedge CLK) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            mon_e = q.pop_front();
            check("valid", VALID, 1);
            check("result", RESULT, mon_e.res);
            check("zero", ZERO, mon_e.zero);
`ifdef ALU_SEQ_OVERFLOW_EN
            check("overflow", OVERFLOW, mon_e.ov);
`endif
            $display("op done: cycle=%0d result=0x%02h zero=%0d expected=0x%02h", cyc, RESULT, ZERO, mon_e.res);
        end else begin
            check("valid_idle", VALID, 0);
        end
    end

    task automatic push_exp(input logic [7:0] r, input logic ov, input int lat);
        exp_t e;
        e.res  = r;
        e.zero = (r == 8'h00);
        e.due  = cyc + lat;
        e.ov   = ov;
        q.push_back(e);
    endtask

    // Called right after a falling edge; leaves START low one cycle later.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic ov, input int lat);
        START  = 1'b1;
        SELECT = op;
        DATA1  = a;
        DATA2  = b;
        push_exp(r, ov, lat);
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", BUSY, (lat > 1));
    endtask

    task automatic wait_idle(input int exp_busy);
        int n = 0;
        while (BUSY && n < 64) begin
            @(negedge CLK);
            n++;
        end
        check("busy_cycles", n, exp_busy);
    endtask

    task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic ov, input int lat);
        issue(op, a, b, r, ov, lat);
        if (lat > 1) wait_idle(lat - 1);
    endtask

    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    int         n_wait;

    initial begin
        repeat (2) @(negedge CLK);
        check("reset_result", RESULT, 8'h00);
        check("reset_zero", ZERO, 1);
        check("reset_busy", BUSY, 0);
        check("reset_valid", VALID, 0);
        RESET = 1'b1;
        @(negedge CLK);

        // Back-to-back single-cycle ops: one VALID per cycle.
        issue(OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b0, 1);
        issue(OP_SUB, 8'h07, 8'h07, 8'h00, 1'b0, 1);
        issue(OP_AND, 8'hCC, 8'hAA, 8'h88, 1'b0, 1);
        issue(OP_OR,  8'hCC, 8'hAA, 8'hEE, 1'b0, 1);
        issue(OP_FWD, 8'h33, 8'h5A, 8'h5A, 1'b0, 1);
        @(negedge CLK);

        run(OP_MUL, 8'd13, 8'd11, 8'h8F, 1'b0, 9);
        run(OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 9);
        run(OP_SLL, 8'h81, 8'h01, 8'h02, 1'b1, 2);
        run(OP_SRA, 8'h80, 8'h07, 8'hFF, 1'b0, 8);
        run(OP_SRA, 8'h80, 8'h08, 8'h80, 1'b0, 1);

        // START held through a MUL with the operands changing underneath it.
        START  = 1'b1;
        SELECT = OP_MUL;
        DATA1  = 8'd13;
        DATA2  = 8'd11;
        push_exp(8'h8F, 1'b0, 9);
        @(negedge CLK);
        n_wait = 0;
        while (BUSY && n_wait < 64) begin
            DATA1 = 8'($urandom);
            DATA2 = 8'($urandom);
            @(negedge CLK);
            n_wait++;
        end
        check("held_busy", n_wait, 8);
        SELECT = OP_ADD;
        DATA1  = 8'd5;
        DATA2  = 8'd3;
        push_exp(8'h08, 1'b0, 1);
        @(negedge CLK);
        START = 1'b0;
        check("held_next_busy", BUSY, 0);

        run(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b1, 1);
        run(OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1);
        run(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1);

        for (int i = 0; i < 16; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = 8'($urandom);
            r_b  = 8'($urandom);
            run(r_op, r_a, r_b, model_res(r_op, r_a, r_b), model_ov(r_op, r_a, r_b), model_lat(r_op, r_b));
        end

        // Asynchronous reset during EXEC cycle 3 of a MUL; that MUL must never complete.
        run(OP_FWD, 8'h00, 8'h5A, 8'h5A, 1'b0, 1);
        START  = 1'b1;
        SELECT = OP_MUL;
        DATA1  = 8'd13;
        DATA2  = 8'd11;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        check("abort_result", RESULT, 8'h00);
        check("abort_zero", ZERO, 1);
        check("abort_busy", BUSY, 0);
        check("abort_valid", VALID, 0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (10) @(negedge CLK);
        run(OP_ADD, 8'd5, 8'd3, 8'h08, 1'b0, 1);

        n_wait = 0;
        while (q.size() > 0 && n_wait < 64) begin
            @(negedge CLK);
            n_wait++;
        end
        check("drain", q.size(), 0);
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
